// File: rtl/arith_fp_pkg.sv
// Shared IEEE-754 field definitions for the arith fp op library.
// Format geometry lookups plus the unpacked-field struct produced by arith_fp_unpack.
package arith_fp_pkg;

    typedef enum logic [2:0] {
        FP_ZERO = 3'd0,
        FP_SUBN = 3'd1,
        FP_NORM = 3'd2,
        FP_INF  = 3'd3,
        FP_NAN  = 3'd4
    } fp_class_e;

    localparam int F32_EXP_W = 8;
    localparam int F32_MAN_W = 23;
    localparam int F32_BIAS  = 127;
    localparam int F64_EXP_W = 11;
    localparam int F64_MAN_W = 52;
    localparam int F64_BIAS  = 1023;

    // Struct is sized for the widest format; narrower formats zero-extend sig.
    localparam int FLD_SIG_W = F64_MAN_W + 1;
    localparam int FLD_E_W   = F64_EXP_W + 2;

    typedef struct packed {
        logic                       sign;
        logic signed [FLD_E_W-1:0]  e;
        logic [FLD_SIG_W-1:0]       sig;
        fp_class_e                  cls;
    } fp_fields_t;

    function automatic int fp_exp_w(input int width);
        return (width == 64) ? F64_EXP_W : F32_EXP_W;
    endfunction

    function automatic int fp_man_w(input int width);
        return (width == 64) ? F64_MAN_W : F32_MAN_W;
    endfunction

    function automatic int fp_bias(input int width);
        return (width == 64) ? F64_BIAS : F32_BIAS;
    endfunction

endpackage

// File: rtl/arith_fp_unpack.sv
// Purpose: split an IEEE-754 operand into sign, unbiased exponent, significand and class.
// Latency: combinational. Backpressure: none, pure function of the operand.
module arith_fp_unpack
    import arith_fp_pkg::*;
#(
    parameter int IN_WIDTH = 32
) (
    input  logic [IN_WIDTH-1:0] op_i,
    output fp_fields_t          fields_o
);

    localparam int EXP_W = fp_exp_w(IN_WIDTH);
    localparam int MAN_W = fp_man_w(IN_WIDTH);
    localparam int BIAS  = fp_bias(IN_WIDTH);

    logic [EXP_W-1:0] exp_raw;
    logic [MAN_W-1:0] man;

    assign exp_raw = op_i[IN_WIDTH-2 -: EXP_W];
    assign man     = op_i[MAN_W-1:0];

    always_comb begin
        fields_o      = '0;
        fields_o.sign = op_i[IN_WIDTH-1];
        fields_o.sig  = FLD_SIG_W'({exp_raw != '0, man});
        fields_o.e    = $signed(FLD_E_W'(exp_raw)) - $signed(FLD_E_W'(BIAS));
        if (exp_raw == '1) begin
            fields_o.cls = (man != '0) ? FP_NAN : FP_INF;
        end else if (exp_raw == '0) begin
            fields_o.cls = (man != '0) ? FP_SUBN : FP_ZERO;
        end else begin
            fields_o.cls = FP_NORM;
        end
    end

endmodule

// File: rtl/arith_fptoui_pipe.sv
// Purpose: IEEE-754 f32/f64 -> unsigned int, truncating and saturating (flags via ARITH_FPTOUI_FLAGS_EN).
// Latency: 2 cycles accept->out_valid, 1 result/cycle. Backpressure: valid/ready, in_ready drops only when both stages hold data.
module arith_fptoui_pipe
    import arith_fp_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data
`ifdef ARITH_FPTOUI_FLAGS_EN
    ,
    output logic [1:0]           out_flags
`endif
);

    localparam int MAN_W = fp_man_w(IN_WIDTH);
    localparam int SH_W  = $clog2((OUT_WIDTH > MAN_W + 1) ? OUT_WIDTH : MAN_W + 1) + 1;
    localparam logic signed [FLD_E_W-1:0] E_OUT = FLD_E_W'(OUT_WIDTH);
    localparam logic signed [FLD_E_W-1:0] E_MAN = FLD_E_W'(MAN_W);

    if (!(IN_WIDTH == 32 || IN_WIDTH == 64)) begin : g_bad_in_width
        $fatal(1, "arith_fptoui_pipe: IN_WIDTH must be 32 or 64");
    end
    if (OUT_WIDTH < 8 || OUT_WIDTH > 64) begin : g_bad_out_width
        $fatal(1, "arith_fptoui_pipe: OUT_WIDTH must be 8..64");
    end

    fp_fields_t            unp_fields;
    fp_fields_t            s1_q;
    logic                  s1_vld_q;
    logic                  s2_vld_q;
    logic [OUT_WIDTH-1:0]  s2_dat_q;
    logic [OUT_WIDTH-1:0]  res_d;
    logic [SH_W-1:0]       lsh;
    logic [SH_W-1:0]       rsh;
    logic                  s2_adv;
    logic                  s1_adv;

    arith_fp_unpack #(
        .IN_WIDTH (IN_WIDTH)
    ) u_unpack (
        .op_i     (in_data),
        .fields_o (unp_fields)
    );

    assign s2_adv   = !s2_vld_q || out_ready;
    assign s1_adv   = !s1_vld_q || s2_adv;
    assign in_ready = s1_adv;

    // Only one of these is meaningful per operand, selected by e vs MAN_W.
    assign lsh = SH_W'(s1_q.e - E_MAN);
    assign rsh = SH_W'(E_MAN - s1_q.e);

    always_comb begin
        res_d = '0;
        if (s1_q.cls == FP_INF && !s1_q.sign) begin
            res_d = '1;
        end else if (s1_q.cls == FP_NORM && !s1_q.sign && !s1_q.e[FLD_E_W-1]) begin
            if (s1_q.e >= E_OUT) begin
                res_d = '1;
            end else if (s1_q.e >= E_MAN) begin
                res_d = OUT_WIDTH'({64'd0, s1_q.sig} << lsh);
            end else begin
                res_d = OUT_WIDTH'(s1_q.sig >> rsh);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
            s2_vld_q <= 1'b0;
            s2_dat_q <= '0;
        end else begin
            if (s1_adv) begin
                s1_vld_q <= in_valid;
            end
            if (s1_adv && in_valid) begin
                s1_q <= unp_fields;
            end
            if (s2_adv) begin
                s2_vld_q <= s1_vld_q;
            end
            if (s2_adv && s1_vld_q) begin
                s2_dat_q <= res_d;
            end
        end
    end

    assign out_valid = s2_vld_q;
    assign out_data  = s2_dat_q;

`ifdef ARITH_FPTOUI_FLAGS_EN
    // flags_d = {invalid, inexact}
    logic [1:0] flags_d;
    logic [1:0] s2_flg_q;

    always_comb begin
        flags_d = 2'b00;
        case (s1_q.cls)
            FP_NAN:  flags_d = 2'b10;
            FP_INF:  flags_d = 2'b10;
            FP_SUBN: flags_d = 2'b01;
            FP_NORM: begin
                if (s1_q.e[FLD_E_W-1]) begin
                    flags_d = 2'b01;
                end else if (s1_q.sign || s1_q.e >= E_OUT) begin
                    flags_d = 2'b10;
                end else if (s1_q.e < E_MAN) begin
                    flags_d[0] = |(s1_q.sig & ((FLD_SIG_W'(1) << rsh) - FLD_SIG_W'(1)));
                end
            end
            default: flags_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_flg_q <= 2'b00;
        end else if (s2_adv && s1_vld_q) begin
            s2_flg_q <= flags_d;
        end
    end

    assign out_flags = s2_flg_q;
`endif

endmodule

// File: tb/tb_arith_fptoui_pipe.sv
// Bench for arith_fptoui_pipe: f32->u32 and f64->u64 instances checked against a real-arithmetic model.
module tb_arith_fptoui_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic        in_valid64, in_ready64, out_valid64;
    logic        out_ready64;
    logic [63:0] in_data64, out_data64;
`ifdef ARITH_FPTOUI_FLAGS_EN
    logic [1:0]  out_flags, out_flags64;
`endif

    always #5 clk = ~clk;

    arith_fptoui_pipe #(.IN_WIDTH(32), .OUT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef ARITH_FPTOUI_FLAGS_EN
        , .out_flags(out_flags)
`endif
    );

    arith_fptoui_pipe #(.IN_WIDTH(64), .OUT_WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_data(in_data64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_data(out_data64)
`ifdef ARITH_FPTOUI_FLAGS_EN
        , .out_flags(out_flags64)
`endif
    );

    typedef struct {
        logic [63:0] d;
        logic [1:0]  f;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        hold_pend = 1'b0;
    logic [31:0] hold_dat = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference: decode to a real value, then apply truncate/saturate rules directly.
    function automatic exp_t ref_conv(input logic [63:0] bits, input int iw, input int ow);
        exp_t res;
        bit   s, nan, inf;
        int   ex;
        real  mag, fl, lim;
        res.d = '0;
        res.f = 2'b00;
        if (iw == 32) begin
            s   = bits[31];
            ex  = int'(bits[30:23]);
            nan = (ex == 255) && (bits[22:0] != 0);
            inf = (ex == 255) && (bits[22:0] == 0);
            mag = (ex == 0) ? real'(bits[22:0]) * 2.0**(-149)
                            : (real'(bits[22:0]) + 2.0**23) * 2.0**(ex - 150);
        end else begin
            s   = bits[63];
            ex  = int'(bits[62:52]);
            nan = (ex == 2047) && (bits[51:0] != 0);
            inf = (ex == 2047) && (bits[51:0] == 0);
            mag = $bitstoreal({1'b0, bits[62:0]});
        end
        lim = 2.0**ow;
        if (nan) begin
            res.f = 2'b10;
        end else if (!s && (inf || mag >= lim)) begin
            res.d = (ow == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << ow) - 64'd1;
            res.f = 2'b10;
        end else if (s && (inf || mag >= 1.0)) begin
            res.f = 2'b10;
        end else if (s && mag != 0.0) begin
            res.f = 2'b01;
        end else if (!s) begin
            fl    = $floor(mag);
            res.d = (fl >= 2.0**63) ? (64'(longint'(fl - 2.0**63)) | 64'h8000_0000_0000_0000)
                                    : 64'(longint'(fl));
            res.f = (mag != fl) ? 2'b01 : 2'b00;
        end
        return res;
    endfunction

    function automatic logic [31:0] gen32();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = {1'($urandom_range(0, 3) == 0), 8'($urandom_range(110, 165)), 23'($urandom)};
            2: case ($urandom_range(0, 5))
                   0: v = 32'h4F80_0000;
                   1: v = 32'h4F7F_FFFF;
                   2: v = 32'hBF80_0000;
                   3: v = 32'hBF7F_FFFF;
                   4: v = 32'h8000_0000;
                   default: v = 32'h3F80_0000;
               endcase
            default: v = {1'($urandom), ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF,
                          ($urandom_range(0, 1) != 0) ? 23'd0 : 23'($urandom)};
        endcase
        return v;
    endfunction

    // Scoreboard for the 32-bit instance: order, content and hold stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            hold_pend = 1'b0;
        end else begin
            if (in_valid && in_ready) sb.push_back(ref_conv({32'd0, in_data}, 32, 32));
            if (hold_pend) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(out_data), 64'(hold_dat));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 64'(out_data), 64'hDEAD);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_data", 64'(out_data), e.d);
`ifdef ARITH_FPTOUI_FLAGS_EN
                    check("sb_flags", 64'(out_flags), 64'(e.f));
`endif
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_dat  = out_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run32(input logic [31:0] op, input logic [31:0] want_d,
                         input logic [1:0] want_f, input string tag);
        int lat;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_data   = op;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd2);
        check({tag, "_data"}, 64'(out_data), 64'(want_d));
`ifdef ARITH_FPTOUI_FLAGS_EN
        check({tag, "_flags"}, 64'(out_flags), 64'(want_f));
`else
        if (want_f == 2'b11) $display("note: unused flag pattern in %s", tag);
`endif
    endtask

    task automatic run64(input logic [63:0] op, input logic [63:0] want_d,
                         input logic [1:0] want_f, input string tag);
        int n;
        @(posedge clk); #1;
        in_valid64 = 1'b1;
        in_data64  = op;
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        n = 0;
        while (!out_valid64 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 64'(out_valid64), 64'd1);
        check({tag, "_data"}, out_data64, want_d);
`ifdef ARITH_FPTOUI_FLAGS_EN
        check({tag, "_flags"}, 64'(out_flags64), 64'(want_f));
`else
        if (want_f == 2'b11) $display("note: unused flag pattern in %s", tag);
`endif
    endtask

    logic [31:0] dir_op [9] = '{32'h3FC0_0000, 32'h4B00_0001, 32'h4F7F_FFFF, 32'h4F80_0000,
                                32'h7F80_0000, 32'hBF00_0000, 32'hBF80_0000, 32'h7FC0_0000,
                                32'h8000_0000};
    logic [31:0] dir_d  [9] = '{32'h0000_0001, 32'h0080_0001, 32'hFFFF_FF00, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [1:0]  dir_f  [9] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00};

    initial begin
        int          idx;
        logic [31:0] bp_op [4];
        logic [63:0] op64;
        exp_t        e64;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in_valid64 = 1'b0; in_data64 = '0; out_ready64 = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_valid64", 64'(out_valid64), 64'd0);
`ifdef ARITH_FPTOUI_FLAGS_EN
        check("rst_out_flags", 64'(out_flags), 64'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 9; i++) run32(dir_op[i], dir_d[i], dir_f[i], $sformatf("dir%0d", i));

        // Backpressure: only two operands fit while the consumer stalls.
        for (int i = 0; i < 4; i++) bp_op[i] = {1'b0, 8'($urandom_range(127, 150)), 23'($urandom)};
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = bp_op[0];
        idx = 0;
        repeat (5) begin
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            if (idx < 4) in_data = bp_op[idx]; else in_valid = 1'b0;
        end
        @(negedge clk);
        check("bp_accepted", 64'(idx), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("bp_stream_valid", 64'(out_valid), 64'd1);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            if (idx < 4) in_data = bp_op[idx]; else in_valid = 1'b0;
        end
        check("bp_all_accepted", 64'(idx), 64'd4);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_drained", 64'(sb.size()), 64'd0);

        // Reset with two operands in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h4120_0000;
        @(posedge clk); #1;
        in_data   = 32'h4140_0000;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_data", 64'(out_data), 64'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no_stale_out", 64'(out_valid), 64'd0);
        end

        // Randomized traffic with random consumer stalls.
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = gen32();
        for (int c = 0; c < 800; c++) begin
            logic took;
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 9) < 7);
            if (took || !in_valid) begin
                in_valid = ($urandom_range(0, 9) < 8);
                in_data  = gen32();
            end
        end
        @(negedge clk);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("rand_drained", 64'(sb.size()), 64'd0);

        // f64 -> u64 instance.
        run64(64'h43F0_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, "f64_2p64");
        run64(64'h41DF_FFFF_FFC0_0000, 64'h0000_0000_7FFF_FFFF, 2'b00, "f64_2p31m1");
        for (int i = 0; i < 20; i++) begin
            op64 = {1'($urandom_range(0, 4) == 0), 11'($urandom_range(1000, 1090)),
                    20'($urandom), 32'($urandom)};
            e64  = ref_conv(op64, 64, 64);
            run64(op64, e64.d, e64.f, $sformatf("f64_rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
